// File: rtl/img_proc_engine.sv
// Image processing engine: one mirror, grayscale or G-channel sharpen pass per start
// over an IMG_H x IMG_W RGB image, with registered address/write outputs.
module img_proc_engine #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CH_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   row,
  output logic [ADDR_W-1:0]   col,
  input  logic [3*CH_W-1:0]   in_pix,
  output logic                out_we,
  output logic [3*CH_W-1:0]   out_pix
);

  localparam int unsigned AccW = CH_W + 5;
  localparam logic [ADDR_W-1:0] RowMax = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(IMG_W - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StMirRd = 3'd1;
  localparam logic [2:0] StMirWr = 3'd2;
  localparam logic [2:0] StGrRd  = 3'd3;
  localparam logic [2:0] StGrWr  = 3'd4;
  localparam logic [2:0] StShRd  = 3'd5;
  localparam logic [2:0] StShWr  = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  // Neighbour index k = 3*kr + kc, with kr/kc in 0..2 standing for offsets -1..+1.
  function automatic logic [1:0] k_row(input logic [3:0] k);
    return (k < 4'd3) ? 2'd0 : (k < 4'd6) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] k_col(input logic [3:0] k);
    return 2'(k - 4'(k_row(k)) * 4'd3);
  endfunction

  // p + d - 1 in ADDR_W+2 bits; the top bit set means the coordinate went negative.
  function automatic logic [ADDR_W+1:0] offs(input logic [ADDR_W-1:0] p, input logic [1:0] d);
    return {2'b00, p} + {{ADDR_W{1'b0}}, d} - {{(ADDR_W + 1){1'b0}}, 1'b1};
  endfunction

  function automatic logic in_lim(input logic [ADDR_W+1:0] v, input int unsigned lim);
    return !v[ADDR_W+1] && (v[ADDR_W:0] < (ADDR_W + 1)'(lim));
  endfunction

  logic [2:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   r_q, r_d, c_q, c_d;
  logic [3:0]          k_q, k_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [ADDR_W-1:0]   row_q, row_d, col_q, col_d;
  logic                we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [3*CH_W-1:0]   pix_q, pix_d;

  logic [CH_W-1:0]     ch_r, ch_g, ch_b, mx, mn, sh_g;
  logic [CH_W:0]       gsum;
  logic [ADDR_W+1:0]   cur_rr, cur_cc, nxt_rr, nxt_cc;
  logic                cur_ok, nxt_ok, last_c, last_pix;
  logic [AccW-1:0]     g_ext, contrib, acc_sum;
  logic [ADDR_W-1:0]   nr, nc, ent_r, ent_c, ent_row, ent_col;
  logic [1:0]          ent_mode;
  logic [2:0]          ent_state;

  // Per-pixel datapath: grayscale midpoint, sharpen accumulation/clamp, raster stepping.
  always_comb begin
    ch_r = in_pix[3*CH_W-1:2*CH_W];
    ch_g = in_pix[2*CH_W-1:CH_W];
    ch_b = in_pix[CH_W-1:0];
    mx = (ch_r > ch_g) ? ch_r : ch_g;
    mx = (mx > ch_b) ? mx : ch_b;
    mn = (ch_r < ch_g) ? ch_r : ch_g;
    mn = (mn < ch_b) ? mn : ch_b;
    gsum = {1'b0, mx} + {1'b0, mn};

    cur_rr = offs(r_q, k_row(k_q));
    cur_cc = offs(c_q, k_col(k_q));
    cur_ok = in_lim(cur_rr, IMG_H) && in_lim(cur_cc, IMG_W);
    nxt_rr = offs(r_q, k_row(4'(k_q + 4'd1)));
    nxt_cc = offs(c_q, k_col(4'(k_q + 4'd1)));
    nxt_ok = in_lim(nxt_rr, IMG_H) && in_lim(nxt_cc, IMG_W);

    g_ext = AccW'(ch_g);
    if (!cur_ok)           contrib = '0;
    else if (k_q == 4'd4)  contrib = g_ext * AccW'(9);
    else                   contrib = AccW'(0) - g_ext;
    acc_sum = acc_q + contrib;
    // Two's-complement accumulator: negative clamps to 0, above channel range to max.
    if (acc_sum[AccW-1])              sh_g = '0;
    else if (|acc_sum[AccW-2:CH_W])   sh_g = '1;
    else                              sh_g = acc_sum[CH_W-1:0];

    last_c   = (c_q == ColMax);
    last_pix = last_c && (r_q == RowMax);
    nc = last_c ? '0 : c_q + 1'b1;
    nr = last_c ? r_q + 1'b1 : r_q;
  end

  // First state and address of the pixel about to be entered (from IDLE or after a write).
  always_comb begin
    ent_mode = (state_q == StIdle) ? mode : mode_q;
    ent_r    = (state_q == StIdle) ? '0 : nr;
    ent_c    = (state_q == StIdle) ? '0 : nc;
    ent_state = StShRd;
    ent_row   = ent_r;
    ent_col   = ent_c;
    case (ent_mode)
      2'd0: begin
        ent_state = StMirRd;
        ent_row   = RowMax - ent_r;
      end
      2'd1: begin
        ent_state = StMirRd;
        ent_col   = ColMax - ent_c;
      end
      2'd2: ent_state = StGrRd;
      default: begin
        // k=0 is (-1,-1): in range only when neither coordinate is on the top/left edge.
        if (ent_r != '0 && ent_c != '0) begin
          ent_row = ent_r - 1'b1;
          ent_col = ent_c - 1'b1;
        end
      end
    endcase
  end

  // Next-state logic; every output register is loaded with its value for the next state.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pix_d   = pix_q;
    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          mode_d  = mode;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = ent_state;
          row_d   = ent_row;
          col_d   = ent_col;
        end
      end
      StMirRd: begin
        state_d = StMirWr;
        row_d   = r_q;
        col_d   = c_q;
        pix_d   = in_pix;
        we_d    = 1'b1;
      end
      StGrRd: begin
        state_d = StGrWr;
        pix_d   = {{CH_W{1'b0}}, gsum[CH_W:1], {CH_W{1'b0}}};
        we_d    = 1'b1;
      end
      StShRd: begin
        acc_d = acc_sum;
        if (k_q == 4'd8) begin
          state_d = StShWr;
          k_d     = '0;
          row_d   = r_q;
          col_d   = c_q;
          pix_d   = {{CH_W{1'b0}}, sh_g, {CH_W{1'b0}}};
          we_d    = 1'b1;
        end else begin
          k_d   = 4'(k_q + 4'd1);
          row_d = nxt_ok ? nxt_rr[ADDR_W-1:0] : r_q;
          col_d = nxt_ok ? nxt_cc[ADDR_W-1:0] : c_q;
        end
      end
      StMirWr, StGrWr, StShWr: begin
        acc_d = '0;
        if (last_pix) begin
          state_d = StDone;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          r_d     = nr;
          c_d     = nc;
          state_d = ent_state;
          row_d   = ent_row;
          col_d   = ent_col;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pix_q   <= pix_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign out_we  = we_q;
  assign out_pix = pix_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_img_proc_engine.sv
// Randomised self-checking bench for img_proc_engine on a 4x4 image.
module tb_img_proc_engine;
  localparam int W = 4;
  localparam int H = 4;
  localparam int AW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n, start, busy, done, out_we;
  logic [1:0] mode;
  logic [AW-1:0] row, col;
  logic [3*CW-1:0] in_pix, out_pix;

  logic [23:0] in_img [H][W];
  logic [23:0] exp_img [H][W];
  logic [29:0] wlog [$];
  int checks = 0, errors = 0;
  int busy_cnt = 0, done_cnt = 0, we_bad = 0, rng_bad = 0;

  img_proc_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .row(row), .col(col), .in_pix(in_pix), .out_we(out_we), .out_pix(out_pix)
  );

  always #5 clk = ~clk;

  assign in_pix = (row < AW'(H) && col < AW'(W)) ? in_img[row][col] : 24'h0;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_we) wlog.push_back({row, col, out_pix});
      if (out_we && !busy) we_bad++;
      if (row >= AW'(H) || col >= AW'(W)) rng_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int gval(input int r, input int c);
    return int'(in_img[r][c][15:8]);
  endfunction

  // Reference: whole output image from the operation definitions.
  task automatic build_exp(input int m);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cr, cg, cb, mx, mn, acc;
        cr = int'(in_img[r][c][23:16]);
        cg = int'(in_img[r][c][15:8]);
        cb = int'(in_img[r][c][7:0]);
        case (m)
          0: exp_img[r][c] = in_img[H-1-r][c];
          1: exp_img[r][c] = in_img[r][W-1-c];
          2: begin
            mx = cr > cg ? cr : cg; mx = mx > cb ? mx : cb;
            mn = cr < cg ? cr : cg; mn = mn < cb ? mn : cb;
            exp_img[r][c] = {8'd0, 8'((mx + mn) / 2), 8'd0};
          end
          default: begin
            acc = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W)
                  acc += (dr == 0 && dc == 0) ? 9 * gval(r, c) : -gval(r+dr, c+dc);
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            exp_img[r][c] = {8'd0, 8'(acc), 8'd0};
          end
        endcase
      end
    end
  endtask

  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) in_img[r][c] = 24'($urandom);
  endtask

  // Writes base..base+15 of the log must be raster-ordered and match exp_img.
  task automatic check_writes(input string nm, input int base);
    for (int i = 0; i < W*H && base + i < wlog.size(); i++) begin
      logic [29:0] e;
      e = wlog[base + i];
      check_eq({nm, "_addr"}, {26'd0, e[29:24]}, {26'd0, 3'(i / W), 3'(i % W)});
      check_eq({nm, "_pix"}, {8'd0, e[23:0]}, {8'd0, exp_img[i / W][i % W]});
    end
  endtask

  task automatic run_op(input string nm, input int m, input int poke);
    busy_cnt = 0; done_cnt = 0; we_bad = 0; rng_bad = 0;
    wlog.delete();
    build_exp(m);
    step();
    start = 1'b1; mode = 2'(m);
    step();
    start = 1'b0; mode = ~2'(m);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      step();
      if (i == poke) begin
        start = 1'b1; mode = ~2'(m);
        step();
        start = 1'b0;
      end
    end
    step(); step();
    check_eq({nm, "_done"}, done_cnt, 1);
    check_eq({nm, "_busy"}, busy_cnt, (m == 3) ? 10*W*H : 2*W*H);
    check_eq({nm, "_nwr"}, wlog.size(), W*H);
    check_eq({nm, "_we_idle"}, we_bad, 0);
    check_eq({nm, "_range"}, rng_bad, 0);
    check_writes(nm, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0;
    #1;
    check_eq("rst_ctl", {busy, done, out_we}, 3'b000);
    check_eq("rst_addr", {row, col}, 6'd0);
    check_eq("rst_pix", out_pix, 24'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Mirrors on the {r,c,55} pattern, then on random images.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) in_img[r][c] = {8'(r), 8'(c), 8'h55};
    run_op("vmir", 0, -1);
    run_op("hmir", 1, -1);
    rand_img(); run_op("vmir_rnd", 0, -1);
    rand_img(); run_op("hmir_rnd", 1, -1);

    // Grayscale with the known corner cases embedded in random pixels.
    rand_img();
    in_img[0][0] = {8'd200, 8'd10, 8'd100};
    in_img[1][1] = {8'd7, 8'd7, 8'd7};
    in_img[2][3] = {8'd255, 8'd0, 8'd1};
    run_op("gray", 2, -1);
    check_eq("gray_200", exp_img[0][0], {8'd0, 8'd105, 8'd0});

    // Sharpen: flat field, single bright pixel, random.
    rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) in_img[r][c][15:8] = 8'd10;
    run_op("sh_flat", 3, -1);
    rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) in_img[r][c][15:8] = 8'd0;
    in_img[1][2][15:8] = 8'd255;
    run_op("sh_spot", 3, -1);
    rand_img(); run_op("sh_rnd", 3, -1);

    // start while busy is ignored (mode stays grayscale).
    rand_img(); run_op("gray_poke", 2, 5);

    // Reset mid-sharpen, with start high during reset.
    rand_img();
    wlog.delete();
    step();
    start = 1'b1; mode = 2'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && wlog.size() < 5; i++) step();
    check_eq("abort_reached", {31'd0, wlog.size() >= 5}, 1);
    #1 rst_n = 1'b0; start = 1'b1;
    #1;
    check_eq("abort_ctl", {busy, done, out_we}, 3'b000);
    check_eq("abort_addr", {row, col}, 6'd0);
    check_eq("abort_pix", out_pix, 24'd0);
    step(); step();
    start = 1'b0; rst_n = 1'b1; done_cnt = 0;
    step(); step(); step();
    check_eq("abort_nodone", done_cnt, 0);
    check_eq("abort_idle", busy, 0);
    rand_img(); run_op("gray_after", 2, -1);

    // start held through DONE: two back-to-back horizontal mirrors.
    rand_img(); build_exp(1);
    busy_cnt = 0; done_cnt = 0; we_bad = 0; rng_bad = 0; wlog.delete();
    step();
    start = 1'b1; mode = 2'd1;
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    step();
    check_eq("b2b_idle", busy, 0);
    step();
    check_eq("b2b_restart", busy, 1);
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt < 2; i++) step();
    step(); step();
    check_eq("b2b_done", done_cnt, 2);
    check_eq("b2b_busy", busy_cnt, 4*W*H);
    check_eq("b2b_nwr", wlog.size(), 2*W*H);
    check_eq("b2b_we_idle", we_bad, 0);
    check_writes("b2b1", 0);
    check_writes("b2b2", W*H);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
